// File: rtl/i2c_slave_pkg.sv
// Shared definitions for the I2C slave engine: FSM encoding and default
// device address / debounce length.
package i2c_slave_pkg;

   localparam logic [6:0] DEV_ADDR_DEF = 7'h50;
   localparam int         DEB_LEN_DEF  = 3;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_RX_DEVADDR,
      ST_ACK_DEV,
      ST_RX_REGADDR,
      ST_ACK_REG,
      ST_RX_DATA,
      ST_ACK_DATA,
      ST_TX_DATA,
      ST_RX_MACK
   } state_e;

endpackage

// File: rtl/i2c_line_filter.sv
// Two-flop synchroniser plus DEB_LEN debounce for one I2C pin, with
// one-clock rise/fall pulses on the filtered level.
module i2c_line_filter
   import i2c_slave_pkg::*;
#(
   parameter int DEB_LEN = DEB_LEN_DEF
) (
   input  logic clk,
   input  logic rst_n,
   input  logic line_i,
   output logic level_o,
   output logic rise_o,
   output logic fall_o
);

   localparam int            CW       = (DEB_LEN > 1) ? $clog2(DEB_LEN) : 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(DEB_LEN - 1);

   logic          sync1_q, sync2_q;
   logic          filt_q, filt_d;
   logic          filt_dly_q;
   logic [CW-1:0] cnt_q, cnt_d;

   // The level only moves after DEB_LEN consecutive samples disagree with it.
   always_comb begin
      filt_d = filt_q;
      cnt_d  = '0;
      if (sync2_q != filt_q) begin
         if (cnt_q == CNT_LAST) begin
            filt_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q    <= 1'b1;
         sync2_q    <= 1'b1;
         filt_q     <= 1'b1;
         filt_dly_q <= 1'b1;
         cnt_q      <= '0;
      end else begin
         sync1_q    <= line_i;
         sync2_q    <= sync1_q;
         filt_q     <= filt_d;
         filt_dly_q <= filt_q;
         cnt_q      <= cnt_d;
      end
   end

   assign level_o = filt_q;
   assign rise_o  = filt_q & ~filt_dly_q;
   assign fall_o  = ~filt_q & filt_dly_q;

endmodule

// File: rtl/i2c_slave_serial.sv
// I2C slave bit engine: START/STOP detection, device address match, byte
// shifting and an auto-incrementing register pointer for a register file.
module i2c_slave_serial
   import i2c_slave_pkg::*;
#(
   parameter logic [6:0] DEV_ADDR = DEV_ADDR_DEF,
   parameter int         DEB_LEN  = DEB_LEN_DEF
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       sclIn,
   input  logic       sdaIn,
   output logic       sdaPullLow,
   output logic [7:0] regAddr,
   output logic [7:0] dataToReg,
   output logic       writeEn,
   input  logic [7:0] dataFromReg,
   output logic       busy
);

   logic scl_lvl, scl_rise, scl_fall;
   logic sda_lvl, sda_rise, sda_fall;

   i2c_line_filter #(.DEB_LEN(DEB_LEN)) u_scl_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_i  (sclIn),
      .level_o (scl_lvl),
      .rise_o  (scl_rise),
      .fall_o  (scl_fall)
   );

   i2c_line_filter #(.DEB_LEN(DEB_LEN)) u_sda_filt (
      .clk     (clk),
      .rst_n   (rst_n),
      .line_i  (sdaIn),
      .level_o (sda_lvl),
      .rise_o  (sda_rise),
      .fall_o  (sda_fall)
   );

   state_e     state_q, state_d;
   logic [3:0] bit_cnt_q, bit_cnt_d;
   logic [7:0] shift_q, shift_d;
   logic       rw_q, rw_d;
   logic       nack_q, nack_d;
   logic       pull_q, pull_d;
   logic [7:0] reg_addr_q, reg_addr_d;
   logic [7:0] data_q, data_d;
   logic       we_q, we_d;
   logic       busy_q, busy_d;

   logic start_det, stop_det, byte_done, addr_match;

   assign start_det  = sda_fall & scl_lvl;
   assign stop_det   = sda_rise & scl_lvl;
   assign byte_done  = (bit_cnt_q == 4'd8);
   assign addr_match = (shift_q[7:1] == DEV_ADDR);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= ST_IDLE;
         bit_cnt_q  <= 4'd0;
         shift_q    <= 8'h00;
         rw_q       <= 1'b0;
         nack_q     <= 1'b0;
         pull_q     <= 1'b0;
         reg_addr_q <= 8'h00;
         data_q     <= 8'h00;
         we_q       <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         bit_cnt_q  <= bit_cnt_d;
         shift_q    <= shift_d;
         rw_q       <= rw_d;
         nack_q     <= nack_d;
         pull_q     <= pull_d;
         reg_addr_q <= reg_addr_d;
         data_q     <= data_d;
         we_q       <= we_d;
         busy_q     <= busy_d;
      end
   end

   // START/STOP win over bit activity in every state.
   always_comb begin
      state_d = state_q;
      if (stop_det) begin
         state_d = ST_IDLE;
      end else if (start_det) begin
         state_d = ST_RX_DEVADDR;
      end else if (scl_fall) begin
         case (state_q)
            ST_RX_DEVADDR: if (byte_done) state_d = addr_match ? ST_ACK_DEV : ST_IDLE;
            ST_ACK_DEV:    state_d = rw_q ? ST_TX_DATA : ST_RX_REGADDR;
            ST_RX_REGADDR: if (byte_done) state_d = ST_ACK_REG;
            ST_ACK_REG:    state_d = ST_RX_DATA;
            ST_RX_DATA:    if (byte_done) state_d = ST_ACK_DATA;
            ST_ACK_DATA:   state_d = ST_RX_DATA;
            ST_TX_DATA:    if (byte_done) state_d = ST_RX_MACK;
            ST_RX_MACK:    state_d = nack_q ? ST_IDLE : ST_TX_DATA;
            default:       state_d = state_q;
         endcase
      end
   end

   always_comb begin
      bit_cnt_d  = bit_cnt_q;
      shift_d    = shift_q;
      rw_d       = rw_q;
      nack_d     = nack_q;
      pull_d     = pull_q;
      reg_addr_d = reg_addr_q;
      data_d     = data_q;
      we_d       = 1'b0;
      busy_d     = busy_q;

      // Pointer advances on the clock following each write strobe.
      if (we_q) reg_addr_d = reg_addr_q + 8'd1;

      if (stop_det) begin
         pull_d = 1'b0;
         busy_d = 1'b0;
      end else if (start_det) begin
         bit_cnt_d = 4'd0;
         pull_d    = 1'b0;
      end else if (scl_rise) begin
         case (state_q)
            ST_RX_DEVADDR, ST_RX_REGADDR, ST_RX_DATA: begin
               shift_d   = {shift_q[6:0], sda_lvl};
               bit_cnt_d = bit_cnt_q + 4'd1;
            end
            ST_RX_MACK: nack_d = sda_lvl;
            default: ;
         endcase
      end else if (scl_fall) begin
         case (state_q)
            ST_RX_DEVADDR: begin
               if (byte_done) begin
                  bit_cnt_d = 4'd0;
                  if (addr_match) begin
                     pull_d = 1'b1;
                     busy_d = 1'b1;
                     rw_d   = shift_q[0];
                  end else begin
                     busy_d = 1'b0;
                  end
               end
            end
            ST_ACK_DEV, ST_RX_MACK: begin
               // Both lead into a read byte unless it is a write or a master NACK.
               bit_cnt_d = 4'd0;
               pull_d    = 1'b0;
               if (state_q == ST_RX_MACK && nack_q) begin
                  busy_d = 1'b0;
               end else if (state_q == ST_RX_MACK || rw_q) begin
                  shift_d   = dataFromReg;
                  pull_d    = ~dataFromReg[7];
                  bit_cnt_d = 4'd1;
               end
            end
            ST_RX_REGADDR: begin
               if (byte_done) begin
                  pull_d     = 1'b1;
                  reg_addr_d = shift_q;
                  bit_cnt_d  = 4'd0;
               end
            end
            ST_ACK_REG, ST_ACK_DATA: begin
               pull_d    = 1'b0;
               bit_cnt_d = 4'd0;
            end
            ST_RX_DATA: begin
               if (byte_done) begin
                  pull_d    = 1'b1;
                  data_d    = shift_q;
                  we_d      = 1'b1;
                  bit_cnt_d = 4'd0;
               end
            end
            ST_TX_DATA: begin
               if (byte_done) begin
                  pull_d     = 1'b0;
                  reg_addr_d = reg_addr_q + 8'd1;
                  bit_cnt_d  = 4'd0;
               end else begin
                  shift_d   = {shift_q[6:0], 1'b0};
                  pull_d    = ~shift_q[6];
                  bit_cnt_d = bit_cnt_q + 4'd1;
               end
            end
            default: ;
         endcase
      end
   end

   assign sdaPullLow = pull_q;
   assign regAddr    = reg_addr_q;
   assign dataToReg  = data_q;
   assign writeEn    = we_q;
   assign busy       = busy_q;

endmodule

// File: tb/tb_i2c_slave_serial.sv
// Bench for i2c_slave_serial: bit-banged I2C master at SCL = clk/40, a
// register-file stand-in, and a transaction-level model of pointer/memory.
module tb_i2c_slave_serial;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       scl_m = 1'b1;
   logic       sda_m = 1'b1;
   logic       sdaPullLow;
   logic [7:0] regAddr, dataToReg, data_from_reg;
   logic       writeEn, busy;
   wire        sda_line = sda_m & ~sdaPullLow;

   int n_checks = 0;
   int n_fail   = 0;

   i2c_slave_serial dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .sclIn       (scl_m),
      .sdaIn       (sda_line),
      .sdaPullLow  (sdaPullLow),
      .regAddr     (regAddr),
      .dataToReg   (dataToReg),
      .writeEn     (writeEn),
      .dataFromReg (data_from_reg),
      .busy        (busy)
   );

   always #5 clk = ~clk;

   // Register file stand-in: registered read, write on strobe.
   logic [7:0] regfile [256];
   bit         rf_init_done = 1'b0;
   always @(posedge clk) begin
      if (!rf_init_done) begin
         for (int i = 0; i < 256; i++) regfile[i] <= 8'(i) ^ 8'hA5;
         rf_init_done <= 1'b1;
      end else if (writeEn) begin
         regfile[regAddr] <= dataToReg;
      end
      data_from_reg <= regfile[regAddr];
   end

   // Transaction-level model: memory image, pointer, expected write stream.
   logic [7:0] exp_mem [256];
   logic [7:0] exp_ptr = 8'h00;
   logic [7:0] wq_addr [$];
   logic [7:0] wq_data [$];

   function automatic bit dev_match(input logic [7:0] b);
      return b[7:1] == 7'h50;
   endfunction

   task automatic model_wdata(input logic [7:0] d);
      wq_addr.push_back(exp_ptr);
      wq_data.push_back(d);
      exp_mem[exp_ptr] = d;
      exp_ptr = exp_ptr + 8'd1;
   endtask

   task automatic model_rdata(output logic [7:0] d);
      d = exp_mem[exp_ptr];
      exp_ptr = exp_ptr + 8'd1;
   endtask

   task automatic check8(input string nm, input logic [7:0] act, input logic [7:0] req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %02h, required %02h", nm, act, req);
      end
   endtask

   task automatic check1(input string nm, input logic act, input logic req);
      n_checks++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL %s: got %0b, required %0b", nm, act, req);
      end
   endtask

   // Per-cycle compare: write strobes against the model stream, and SDA
   // drive must hold steady while SCL is high.
   logic [7:0] ea, ed;
   logic       rst_prev = 1'b0, scl_prev = 1'b1, pull_prev = 1'b0;
   always begin
      @(posedge clk);
      #2;
      if (rst_n && rst_prev) begin
         if (writeEn) begin
            n_checks++;
            if (wq_addr.size() == 0) begin
               n_fail++;
               $display("FAIL wr_strobe: unexpected write addr %02h data %02h, required none", regAddr, dataToReg);
            end else begin
               ea = wq_addr.pop_front();
               ed = wq_data.pop_front();
               if (regAddr !== ea || dataToReg !== ed) begin
                  n_fail++;
                  $display("FAIL wr_strobe: got addr %02h data %02h, required addr %02h data %02h", regAddr, dataToReg, ea, ed);
               end
            end
         end
         if (scl_m && scl_prev) begin
            n_checks++;
            if (sdaPullLow !== pull_prev) begin
               n_fail++;
               $display("FAIL sda_stable: sdaPullLow went %0b while SCL high, required %0b", sdaPullLow, pull_prev);
            end
         end
      end
      rst_prev  = rst_n;
      scl_prev  = scl_m;
      pull_prev = sdaPullLow;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached, required completion");
      $fatal(1, "watchdog expired");
   end

   // ---------------- master BFM ----------------
   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic start_c();
      sda_m = 1'b1; tick(10);
      scl_m = 1'b1; tick(10);
      sda_m = 1'b0; tick(10);
      scl_m = 1'b0; tick(10);
   endtask

   task automatic stop_c();
      sda_m = 1'b0; tick(10);
      scl_m = 1'b1; tick(10);
      sda_m = 1'b1; tick(20);
   endtask

   // gkind 1: 2-clk SCL pulse in the low phase; 2: 2-clk SDA flip in the high phase.
   task automatic send_bit(input logic b, input int gkind);
      sda_m = b;
      if (gkind == 1) begin
         tick(4); scl_m = 1'b1; tick(2); scl_m = 1'b0; tick(4);
      end else begin
         tick(10);
      end
      scl_m = 1'b1;
      if (gkind == 2) begin
         tick(8); sda_m = ~b; tick(2); sda_m = b; tick(10);
      end else begin
         tick(20);
      end
      scl_m = 1'b0; tick(10);
   endtask

   task automatic recv_bit(output logic r);
      sda_m = 1'b1; tick(10);
      scl_m = 1'b1; tick(10);
      r = sda_line; tick(10);
      scl_m = 1'b0; tick(10);
   endtask

   task automatic send_byte(input logic [7:0] b, input int gbit, input int gkind, output logic ack);
      logic r;
      for (int i = 0; i < 8; i++) send_bit(b[7-i], (i == gbit) ? gkind : 0);
      recv_bit(r);
      ack = ~r;
   endtask

   task automatic recv_byte(input logic ack_m, output logic [7:0] d);
      logic r;
      for (int i = 0; i < 8; i++) begin
         recv_bit(r);
         d[7-i] = r;
      end
      send_bit(~ack_m, 0);
   endtask

   // ---------------- directed sequence ----------------
   logic       a;
   logic [7:0] rd, exp_rd;

   initial begin
      for (int i = 0; i < 256; i++) exp_mem[i] = 8'(i) ^ 8'hA5;
      tick(5);
      check1("reset sdaPullLow", sdaPullLow, 1'b0);
      check8("reset regAddr", regAddr, 8'h00);
      check8("reset dataToReg", dataToReg, 8'h00);
      check1("reset writeEn", writeEn, 1'b0);
      check1("reset busy", busy, 1'b0);
      rst_n = 1'b1;
      tick(10);

      // 1: simple write, with an SCL glitch inside the data byte
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t1 dev ack", a, dev_match(8'hA0));
      check1("t1 busy", busy, 1'b1);
      send_byte(8'h05, -1, 0, a); check1("t1 reg ack", a, 1'b1); exp_ptr = 8'h05;
      model_wdata(8'h3C);
      send_byte(8'h3C, 2, 1, a); check1("t1 data ack", a, 1'b1);
      stop_c();
      check1("t1 busy after stop", busy, 1'b0);
      check8("t1 dataToReg", dataToReg, 8'h3C);
      check8("t1 regAddr", regAddr, 8'h06);

      // 2: random read of three bytes
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t2 dev ack", a, 1'b1);
      send_byte(8'h10, -1, 0, a); check1("t2 reg ack", a, 1'b1); exp_ptr = 8'h10;
      start_c();
      send_byte(8'hA1, -1, 0, a); check1("t2 rd dev ack", a, dev_match(8'hA1));
      for (int i = 0; i < 3; i++) begin
         model_rdata(exp_rd);
         recv_byte(i != 2, rd);
         check8($sformatf("t2 read %0d", i), rd, exp_rd);
         if (i == 0) check8("t2 read0 literal", rd, 8'hB5);
      end
      check1("t2 busy after nack", busy, 1'b0);
      stop_c();
      check8("t2 regAddr", regAddr, 8'h13);
      check8("t2 regAddr model", regAddr, exp_ptr);

      // 3: foreign address is ignored
      start_c();
      send_byte(8'hA2, -1, 0, a); check1("t3 no ack", a, dev_match(8'hA2));
      check1("t3 busy", busy, 1'b0);
      stop_c();
      check8("t3 regAddr unchanged", regAddr, exp_ptr);

      // 4: pointer wrap, with an SDA glitch while SCL high
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t4 dev ack", a, 1'b1);
      send_byte(8'hFF, -1, 0, a); check1("t4 reg ack", a, 1'b1); exp_ptr = 8'hFF;
      model_wdata(8'h11);
      send_byte(8'h11, 3, 2, a); check1("t4 data0 ack", a, 1'b1);
      model_wdata(8'h22);
      send_byte(8'h22, -1, 0, a); check1("t4 data1 ack", a, 1'b1);
      stop_c();
      check8("t4 regAddr", regAddr, 8'h01);
      check8("t4 dataToReg", dataToReg, 8'h22);

      // 5: START after 4 data bits aborts the byte
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t5 dev ack", a, 1'b1);
      send_byte(8'h20, -1, 0, a); check1("t5 reg ack", a, 1'b1); exp_ptr = 8'h20;
      for (int i = 0; i < 4; i++) send_bit(1'b1, 0);
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t5 re dev ack", a, 1'b1);
      send_byte(8'h21, -1, 0, a); check1("t5 re reg ack", a, 1'b1); exp_ptr = 8'h21;
      model_wdata(8'h77);
      send_byte(8'h77, -1, 0, a); check1("t5 data ack", a, 1'b1);
      stop_c();
      check8("t5 regAddr", regAddr, exp_ptr);

      // 6: reset while the slave drives a 0 bit
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t6 dev ack", a, 1'b1);
      send_byte(8'h90, -1, 0, a); check1("t6 reg ack", a, 1'b1); exp_ptr = 8'h90;
      start_c();
      send_byte(8'hA1, -1, 0, a); check1("t6 rd dev ack", a, 1'b1);
      check1("t6 tx drive", sdaPullLow, ~exp_mem[exp_ptr][7]);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check1("t6 rst sdaPullLow", sdaPullLow, 1'b0);
      check8("t6 rst regAddr", regAddr, 8'h00);
      check8("t6 rst dataToReg", dataToReg, 8'h00);
      check1("t6 rst writeEn", writeEn, 1'b0);
      check1("t6 rst busy", busy, 1'b0);
      scl_m = 1'b1;
      sda_m = 1'b1;
      tick(5);
      rst_n = 1'b1;
      exp_ptr = 8'h00;
      tick(20);

      // recovery write after reset
      start_c();
      send_byte(8'hA0, -1, 0, a); check1("t7 dev ack", a, 1'b1);
      send_byte(8'h02, -1, 0, a); check1("t7 reg ack", a, 1'b1); exp_ptr = 8'h02;
      model_wdata(8'h5A);
      send_byte(8'h5A, -1, 0, a); check1("t7 data ack", a, 1'b1);
      stop_c();
      check8("t7 regAddr", regAddr, 8'h03);
      tick(10);
      check8("pending writes", 8'(wq_addr.size()), 8'h00);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
